// File: rtl/lsu_bus_master.sv
// RV32I load/store unit that turns an M-stage memory access into one valid/ready
// request plus response transaction, stalling the pipeline until the access completes.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        errM,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;

  state_t        state_r, state_nx_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    funct3_r;
  logic [1:0]    off_r;
  logic [31:0]   readdata_r;
  logic          err_r;
  logic          req_valid_r, we_r;
  logic [31:0]   addr_r, wdata_r;
  logic [3:0]    wstrb_r;

  logic          access_s, legal_s, misal_s, start_s, timeout_s;
  logic          stall_s, misalign_s;
  logic [3:0]    wstrb_s;
  logic [31:0]   wdata_s;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      3'b010:  load_extract = w;
      default: load_extract = 32'd0;
    endcase
  endfunction

  // Decode legality, alignment and store lane steering of the incoming access.
  always_comb begin
    access_s = memreadM | memwriteM;
    case (funct3M)
      3'b000, 3'b001, 3'b010: legal_s = 1'b1;
      3'b100, 3'b101:         legal_s = ~memwriteM;
      default:                legal_s = 1'b0;
    endcase
    misal_s = ((funct3M[1:0] == 2'b01) & aluoutM[0]) |
              ((funct3M[1:0] == 2'b10) & (aluoutM[1:0] != 2'b00));
    start_s = (state_r == IDLE) & access_s & legal_s & ~misal_s;
    wstrb_s = 4'b0000;
    wdata_s = writedataM;
    if (memwriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          wstrb_s = 4'b0001 << aluoutM[1:0];
          wdata_s = {4{writedataM[7:0]}};
        end
        2'b01: begin
          wstrb_s = aluoutM[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{writedataM[15:0]}};
        end
        2'b10:   wstrb_s = 4'b1111;
        default: wstrb_s = 4'b0000;
      endcase
    end else begin
      wstrb_s = 4'b0000;
    end
  end

  assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_r == TO_LAST);

  // Next-state and combinational pipeline handshake outputs.
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    misalign_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nx_s = REQ;
          stall_s    = 1'b1;
        end else if (access_s) begin
          misalign_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (timeout_s) begin
          state_nx_s = DONE;
        end else if (req_valid_r && bus_req_ready) begin
          state_nx_s = RSP;
        end else begin
          state_nx_s = REQ;
        end
      end
      RSP: begin
        stall_s = 1'b1;
        if (bus_rsp_valid || timeout_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RSP;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // A held access must not stall the pipe while reset is asserted.
  assign stallM    = stall_s & ~reset;
  assign misalignM = misalign_s & ~reset;

  // State, request fields, timeout counter and DONE-cycle result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      req_valid_r <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      wstrb_r     <= 4'd0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      cnt_r       <= '0;
      readdata_r  <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      req_valid_r <= (state_nx_s == REQ);
      if (start_s) begin
        we_r     <= memwriteM;
        addr_r   <= {aluoutM[31:2], 2'b00};
        wdata_r  <= wdata_s;
        wstrb_r  <= wstrb_s;
        funct3_r <= funct3M;
        off_r    <= aluoutM[1:0];
        cnt_r    <= '0;
      end else if ((state_r == REQ) || (state_r == RSP)) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if ((state_r == RSP) && bus_rsp_valid) begin
        err_r      <= bus_rsp_err;
        readdata_r <= (we_r || bus_rsp_err) ? 32'd0 : load_extract(funct3_r, off_r, bus_rsp_rdata);
      end else if (state_nx_s == DONE) begin
        err_r      <= 1'b1;
        readdata_r <= 32'd0;
      end else begin
        err_r      <= 1'b0;
        readdata_r <= 32'd0;
      end
    end
  end

  assign readdataM     = readdata_r;
  assign errM          = err_r;
  assign bus_req_valid = req_valid_r;
  assign bus_we        = we_r;
  assign bus_addr      = addr_r;
  assign bus_wdata     = wdata_r;
  assign bus_wstrb     = wstrb_r;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: a scripted responder drives the bus and a
// queue of expected DONE-cycle results is checked as each access completes.
module tb_lsu_bus_master;

  logic        clk, reset;
  logic        memreadM, memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        stallM, misalignM, errM;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rsp_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid, bus_rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  lsu_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .memreadM(memreadM), .memwriteM(memwriteM), .funct3M(funct3M),
    .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .misalignM(misalignM), .errM(errM),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic drop_inputs();
    memreadM = 1'b0; memwriteM = 1'b0; funct3M = 3'd0; aluoutM = 32'd0; writedataM = 32'd0;
  endtask

  // Issue one legal access from IDLE, respond as scripted, and check it against the queue.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input int ready_dly,
                            input int rsp_dly, input logic [31:0] rsp_data, input logic rsp_e,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                            input int exp_stalls);
    int   stalls, req_cycles, cd;
    logic done, accepted;
    exp_t e;
    memreadM = rd; memwriteM = wr; funct3M = f3; aluoutM = addr; writedataM = wd;
    stalls = 0; req_cycles = 0; cd = 0; done = 1'b0; accepted = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!stallM) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          check({tag, " queue"}, 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check({tag, " readdataM"}, readdataM, e.rdata);
          check({tag, " errM"}, {31'd0, errM}, {31'd0, e.err});
        end
        check({tag, " valid_in_done"}, {31'd0, bus_req_valid}, 32'd0);
        check({tag, " stall_cycles"}, stalls, exp_stalls);
      end else begin
        stalls++;
        if (bus_req_valid) begin
          check({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, wr});
          check({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
          check({tag, " bus_wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_strb});
          if (wr) check({tag, " bus_wdata"}, bus_wdata, exp_wdata);
          if (req_cycles >= ready_dly) bus_req_ready = 1'b1;
          req_cycles++;
        end else if (accepted && cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus_rsp_valid = 1'b1; bus_rsp_rdata = rsp_data; bus_rsp_err = rsp_e;
          end
        end
      end
      @(posedge clk); #1;
      if (bus_req_ready) begin
        bus_req_ready = 1'b0; accepted = 1'b1; cd = rsp_dly;
      end
      bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_rdata = 32'd0;
    end
    if (!done) check({tag, " completion"}, {31'd0, done}, 32'd1);
    drop_inputs();
  endtask

  // An illegal or misaligned access must flag at once and never touch the bus.
  task automatic run_reject(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr);
    logic rose;
    memreadM = rd; memwriteM = wr; funct3M = f3; aluoutM = addr; writedataM = 32'hA5A5A5A5;
    rose = 1'b0;
    @(negedge clk);
    check({tag, " misalignM"}, {31'd0, misalignM}, 32'd1);
    check({tag, " stallM"}, {31'd0, stallM}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_req_valid) rose = 1'b1;
    end
    check({tag, " no_request"}, {31'd0, rose}, 32'd0);
    @(posedge clk); #1;
    drop_inputs();
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    drop_inputs();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst stallM", {31'd0, stallM}, 32'd0);
    check("rst misalignM", {31'd0, misalignM}, 32'd0);
    check("rst errM", {31'd0, errM}, 32'd0);
    check("rst readdataM", readdataM, 32'd0);
    check("rst bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
    check("rst bus_we", {31'd0, bus_we}, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    push_exp(32'hDEADBEEF, 1'b0);
    run_access("lw100", 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEADBEEF, 1'b0, 4'b0000, 32'd0, 3);
    push_exp(32'hFFFFFF80, 1'b0);
    run_access("lb103", 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 1, 32'h80FF0102, 1'b0, 4'b0000, 32'd0, 3);
    push_exp(32'h00000080, 1'b0);
    run_access("lbu103", 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 1, 32'h80FF0102, 1'b0, 4'b0000, 32'd0, 3);
    push_exp(32'h000080FF, 1'b0);
    run_access("lhu102", 1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 0, 1, 32'h80FF0102, 1'b0, 4'b0000, 32'd0, 3);
    push_exp(32'hFFFF80FF, 1'b0);
    run_access("lh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 1, 2, 32'h80FF0102, 1'b0, 4'b0000, 32'd0, 5);
    push_exp(32'h00000102, 1'b0);
    run_access("lh100", 1'b1, 1'b0, 3'b001, 32'h100, 32'd0, 0, 1, 32'h80FF0102, 1'b0, 4'b0000, 32'd0, 3);
    push_exp(32'hFFFFFFFF, 1'b0);
    run_access("lb101", 1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 0, 1, 32'h1234FF00, 1'b0, 4'b0000, 32'd0, 3);

    push_exp(32'd0, 1'b0);
    run_access("sb102", 1'b0, 1'b1, 3'b000, 32'h102, 32'h12345678, 0, 1, 32'hFFFFFFFF, 1'b0, 4'b0100, 32'h78787878, 3);
    push_exp(32'd0, 1'b0);
    run_access("sh102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h12345678, 0, 1, 32'd0, 1'b0, 4'b1100, 32'h56785678, 3);
    push_exp(32'd0, 1'b0);
    run_access("sw104", 1'b1, 1'b1, 3'b010, 32'h104, 32'h12345678, 2, 3, 32'd0, 1'b0, 4'b1111, 32'h12345678, 7);

    run_reject("lw101", 1'b1, 1'b0, 3'b010, 32'h101);
    run_reject("ld011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_reject("sh101", 1'b0, 1'b1, 3'b001, 32'h101);
    run_reject("st100", 1'b0, 1'b1, 3'b100, 32'h100);

    push_exp(32'd0, 1'b1);
    run_access("lwerr", 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 0, 1, 32'hCAFEF00D, 1'b1, 4'b0000, 32'd0, 3);

    push_exp(32'd0, 1'b1);
    run_access("tmo", 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1000, 1, 32'd0, 1'b0, 4'b0000, 32'd0, 9);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFFFFFF; bus_rsp_err = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;
    @(negedge clk);
    check("late errM", {31'd0, errM}, 32'd0);
    check("late readdataM", readdataM, 32'd0);
    check("late stallM", {31'd0, stallM}, 32'd0);
    check("late bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
    @(posedge clk); #1;

    memreadM = 1'b1; funct3M = 3'b010; aluoutM = 32'h400;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus_req_valid) seen = 1'b1;
    end
    check("midrst reached_req", {31'd0, seen}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
    check("midrst stallM", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    drop_inputs();
    reset = 1'b0;
    @(posedge clk); #1;

    push_exp(32'h13579BDF, 1'b0);
    run_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 0, 1, 32'h13579BDF, 1'b0, 4'b0000, 32'd0, 3);

    check("queue drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
